// File: rtl/mips_pkg.sv
// MIPS subset constants: op_sel encoding, opcodes, functs,
// encoder FSM states and field bundle.
package mips_pkg;

  typedef enum logic [3:0] {
    OP_LW   = 4'd0,
    OP_SW   = 4'd1,
    OP_ADDI = 4'd2,
    OP_ANDI = 4'd3,
    OP_ORI  = 4'd4,
    OP_ADD  = 4'd5,
    OP_SUB  = 4'd6,
    OP_AND  = 4'd7,
    OP_OR   = 4'd8,
    OP_SLT  = 4'd9,
    OP_SLL  = 4'd10,
    OP_SRL  = 4'd11,
    OP_BEQ  = 4'd12,
    OP_BNE  = 4'd13
  } op_sel_e;

  localparam logic [5:0] OPC_RTYPE = 6'b000000;
  localparam logic [5:0] OPC_LW    = 6'b100011;
  localparam logic [5:0] OPC_SW    = 6'b101011;
  localparam logic [5:0] OPC_ADDI  = 6'b001000;
  localparam logic [5:0] OPC_ANDI  = 6'b001100;
  localparam logic [5:0] OPC_ORI   = 6'b001101;
  localparam logic [5:0] OPC_BEQ   = 6'b000100;
  localparam logic [5:0] OPC_BNE   = 6'b000101;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;

  localparam logic [7:0] ADDR_LAST = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_FULL = 2'd2
  } enc_state_e;

  typedef struct packed {
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [15:0] imm;
  } instr_fields_t;

  function automatic logic [31:0] i_word(
    input logic [5:0]  opc,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [15:0] imm
  );
    return {opc, rs, rt, imm};
  endfunction

  function automatic logic [31:0] r_word(
    input logic [4:0] rs,
    input logic [4:0] rt,
    input logic [4:0] rd,
    input logic [4:0] sh,
    input logic [5:0] fn
  );
    return {OPC_RTYPE, rs, rt, rd, sh, fn};
  endfunction

endpackage

// File: rtl/instr_word_enc.sv
// Combinational field-to-word mapping for the MIPS subset.
// Arithmetic R-types drop shamt; shifts drop rs.
module instr_word_enc
  import mips_pkg::*;
(
  input  logic [3:0]    op_sel,
  input  instr_fields_t f,
  output logic [31:0]   word,
  output logic          legal
);

  always_comb begin
    word  = '0;
    legal = 1'b1;
    unique case (1'b1)
      (op_sel == OP_LW):
        word = i_word(OPC_LW, f.rs, f.rt, f.imm);
      (op_sel == OP_SW):
        word = i_word(OPC_SW, f.rs, f.rt, f.imm);
      (op_sel == OP_ADDI):
        word = i_word(OPC_ADDI, f.rs, f.rt, f.imm);
      (op_sel == OP_ANDI):
        word = i_word(OPC_ANDI, f.rs, f.rt, f.imm);
      (op_sel == OP_ORI):
        word = i_word(OPC_ORI, f.rs, f.rt, f.imm);
      (op_sel == OP_ADD):
        word = r_word(f.rs, f.rt, f.rd, 5'd0, FN_ADD);
      (op_sel == OP_SUB):
        word = r_word(f.rs, f.rt, f.rd, 5'd0, FN_SUB);
      (op_sel == OP_AND):
        word = r_word(f.rs, f.rt, f.rd, 5'd0, FN_AND);
      (op_sel == OP_OR):
        word = r_word(f.rs, f.rt, f.rd, 5'd0, FN_OR);
      (op_sel == OP_SLT):
        word = r_word(f.rs, f.rt, f.rd, 5'd0, FN_SLT);
      (op_sel == OP_SLL):
        word = r_word(5'd0, f.rt, f.rd, f.shamt, FN_SLL);
      (op_sel == OP_SRL):
        word = r_word(5'd0, f.rt, f.rd, f.shamt, FN_SRL);
      (op_sel == OP_BEQ):
        word = i_word(OPC_BEQ, f.rs, f.rt, f.imm);
      (op_sel == OP_BNE):
        word = i_word(OPC_BNE, f.rs, f.rt, f.imm);
      default:
        legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Instruction-memory loader: encodes fields and writes
// one word per cycle into a 256-word memory.
module instr_encoder
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        finish,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  op_sel,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [15:0] imm,
  output logic        mem_we,
  output logic [7:0]  mem_addr,
  output logic [31:0] mem_wdata,
  output logic [8:0]  word_count,
  output logic        done,
  output logic        err
);

  enc_state_e    state, state_nx;
  instr_fields_t fields;
  logic [7:0]    addr_q;
  logic [31:0]   word;
  logic          legal;
  logic          xfer;
  logic          wr;
  logic          ill;
  logic          sess_start;
  logic          sess_end;

  assign fields = '{
    rs:    rs,
    rt:    rt,
    rd:    rd,
    shamt: shamt,
    imm:   imm
  };

  instr_word_enc u_enc (
    .op_sel (op_sel),
    .f      (fields),
    .word   (word),
    .legal  (legal)
  );

  always_comb begin
    state_nx   = state;
    in_ready   = 1'b0;
    xfer       = 1'b0;
    sess_start = 1'b0;
    sess_end   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          sess_start = 1'b1;
          state_nx   = ST_LOAD;
        end
      end
      ST_LOAD: begin
        in_ready = 1'b1;
        xfer     = in_valid;
        // finish wins the state, but the transfer still lands
        if (finish) begin
          sess_end = 1'b1;
          state_nx = ST_IDLE;
        end else if (in_valid && legal &&
                     addr_q == ADDR_LAST) begin
          state_nx = ST_FULL;
        end
      end
      ST_FULL: begin
        if (finish) begin
          sess_end = 1'b1;
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  assign wr  = xfer & legal;
  assign ill = xfer & ~legal;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      addr_q     <= '0;
      word_count <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state  <= state_nx;
      mem_we <= wr;
      err    <= ill;
      done   <= sess_end;
      if (sess_start) begin
        addr_q     <= '0;
        word_count <= '0;
      end else if (wr) begin
        addr_q     <= addr_q + 8'd1;
        word_count <= word_count + 9'd1;
        mem_addr   <= addr_q;
        mem_wdata  <= word;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: a session model predicts
// writes/err/done; a negedge monitor pops and compares.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, finish, in_valid, in_ready;
  logic [3:0]  op_sel;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;
  logic        mem_we, done, err;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [8:0]  word_count;

  instr_encoder dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .finish     (finish),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op_sel     (op_sel),
    .rs         (rs),
    .rt         (rt),
    .rd         (rd),
    .shamt      (shamt),
    .imm        (imm),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .word_count (word_count),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // kind: 0 write, 1 err, 2 done
  typedef struct {
    int          kind;
    int          cycle;
    int          addr;
    logic [31:0] data;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  logic [31:0] last_wdata = '0;

  // model: 0 idle, 1 load, 2 full
  int mst  = 0;
  int madr = 0;
  int mcnt = 0;

  localparam int OPC [14] =
    '{35, 43, 8, 12, 13, 0, 0, 0, 0, 0, 0, 0, 4, 5};
  localparam int FUN [14] =
    '{0, 0, 0, 0, 0, 32, 34, 36, 37, 42, 0, 2, 0, 0};

  function automatic logic [31:0] ref_enc(
    input int op, input int a_rs, input int a_rt,
    input int a_rd, input int a_sh, input int a_imm
  );
    longint w;
    int s = a_rs;
    int h = a_sh;
    if (op >= 5 && op <= 11) begin
      if (op >= 10) s = 0;
      else h = 0;
      w = longint'(s) * (1 << 21) + longint'(a_rt) * (1 << 16)
        + longint'(a_rd) * (1 << 11) + h * 64 + FUN[op];
    end else begin
      w = longint'(OPC[op]) * 64'd67108864
        + longint'(s) * (1 << 21) + longint'(a_rt) * (1 << 16)
        + a_imm;
    end
    return w[31:0];
  endfunction

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t",
               name, act, req, $time);
    end
  endtask

  task automatic push(input int k, input int a,
                      input logic [31:0] d);
    exp_t e;
    e.kind  = k;
    e.cycle = cyc + 1;
    e.addr  = a;
    e.data  = d;
    q.push_back(e);
  endtask

  task automatic pop_check(input int k);
    exp_t e;
    if (q.size() == 0) begin
      check("unexpected_output", 64'(k), 64'hFF);
      return;
    end
    e = q.pop_front();
    check("out_kind", 64'(k), 64'(e.kind));
    check("out_cycle", 64'(cyc), 64'(e.cycle));
    if (k == 0 && e.kind == 0) begin
      check("mem_addr", 64'(mem_addr), 64'(e.addr));
      check("mem_wdata", 64'(mem_wdata), 64'(e.data));
      last_wdata = e.data;
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      last_wdata = '0;
    end else begin
      if (mem_we) pop_check(0);
      else check("wdata_hold", 64'(mem_wdata), 64'(last_wdata));
      if (err)  pop_check(1);
      if (done) pop_check(2);
      while (q.size() > 0 && q[0].cycle <= cyc) begin
        check("missed_output", 64'hFF, 64'(q[0].kind));
        void'(q.pop_front());
      end
    end
  end

  // Called at posedge+1; drives one cycle and advances the model.
  task automatic step(input bit s, input bit fin, input bit v,
                      input int op, input int a_rs, input int a_rt,
                      input int a_rd, input int a_sh, input int a_imm);
    int nst;
    check("in_ready", 64'(in_ready), 64'(mst == 1));
    check("word_count", 64'(word_count), 64'(mcnt));
    start    = s;
    finish   = fin;
    in_valid = v;
    op_sel   = 4'(op);
    rs       = 5'(a_rs);
    rt       = 5'(a_rt);
    rd       = 5'(a_rd);
    shamt    = 5'(a_sh);
    imm      = 16'(a_imm);
    nst = mst;
    if (mst == 0) begin
      if (s) begin
        nst  = 1;
        madr = 0;
        mcnt = 0;
      end
    end else begin
      if (mst == 1 && v) begin
        if (op < 14) begin
          push(0, madr,
               ref_enc(op, a_rs, a_rt, a_rd, a_sh, a_imm));
          madr++;
          mcnt++;
          if (mcnt == 256) nst = 2;
        end else begin
          push(1, 0, '0);
        end
      end
      if (fin) begin
        push(2, 0, '0);
        nst = 0;
      end
    end
    mst = nst;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic rnd_xfer(input bit v, input int op);
    step(0, 0, v, op,
         $urandom_range(0, 31), $urandom_range(0, 31),
         $urandom_range(0, 31), $urandom_range(0, 31),
         $urandom_range(0, 65535));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_in_ready"}, 64'(in_ready), 0);
    check({tag, "_mem_we"}, 64'(mem_we), 0);
    check({tag, "_done"}, 64'(done), 0);
    check({tag, "_err"}, 64'(err), 0);
    check({tag, "_mem_addr"}, 64'(mem_addr), 0);
    check({tag, "_mem_wdata"}, 64'(mem_wdata), 0);
    check({tag, "_word_count"}, 64'(word_count), 0);
  endtask

  initial begin
    rst = 1'b1;
    start = 0; finish = 0; in_valid = 0; op_sel = 0;
    rs = 0; rt = 0; rd = 0; shamt = 0; imm = 0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;
    idle();

    // directed encodings
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 1, 2, 9, 9, 16'h0004);
    step(0, 0, 1, 5, 1, 2, 3, 7, 16'h1234);
    step(0, 0, 1, 10, 6, 2, 3, 4, 16'hABCD);
    idle();
    step(0, 1, 0, 0, 0, 0, 0, 0, 0);
    idle();

    // illegal op between two legal words
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    rnd_xfer(1, 2);
    rnd_xfer(1, 14);
    rnd_xfer(1, 7);
    rnd_xfer(1, 15);
    idle();

    // finish together with a beq transfer
    step(0, 1, 1, 12, 4, 5, 0, 0, 16'hFFFE);
    idle();
    step(0, 1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 1, 1, 1, 1, 1);

    // random session
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 150; i++)
      rnd_xfer($urandom_range(0, 9) < 7, $urandom_range(0, 15));
    step(0, 1, 1, $urandom_range(0, 13), 3, 4, 5, 6, 7);
    idle();

    // fill all 256 words, then a 257th valid
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 256; i++)
      rnd_xfer(1, $urandom_range(0, 13));
    rnd_xfer(1, 3);
    rnd_xfer(1, 14);
    check("full_count", 64'(word_count), 256);
    check("full_ready", 64'(in_ready), 0);
    step(0, 1, 0, 0, 0, 0, 0, 0, 0);
    idle();
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    rnd_xfer(1, 1);
    step(0, 1, 0, 0, 0, 0, 0, 0, 0);
    idle();

    // reset with a write in flight
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    rnd_xfer(1, 4);
    rnd_xfer(1, 6);
    rnd_xfer(1, 11);
    rst = 1'b1;
    in_valid = 0;
    q.delete();
    mst = 0; madr = 0; mcnt = 0;
    #1;
    check_zero("midrst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) idle();
    check_zero("postrst");

    repeat (3) idle();
    check("queue_empty", 64'(q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
